// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths, writeback beat and source-select types for rf_writeback
package rf_wb_pkg;
  localparam int DWIDTH = 16;
  localparam int AWIDTH = 3;
  typedef struct packed {
    logic [AWIDTH-1:0] regsel;
    logic [DWIDTH-1:0] data;
  } beat_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_LD, SRC_FIFO, SRC_ALU} src_t;
endpackage

// File: rtl/rf_writeback_fifo.sv
// wb_skid_fifo: DEPTH-entry beat FIFO with full/empty and oldest-first entry visibility
module wb_skid_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  beat_t            din,
  output beat_t            head,
  output logic             full,
  output logic             empty,
  output beat_t            ent [DEPTH],
  output logic [DEPTH-1:0] vld
);
  localparam int PW = $clog2(DEPTH) + 1;
  logic [PW-1:0] wp, rp, cnt;
  beat_t mem [DEPTH];
  assign cnt = wp - rp;
  assign empty = wp == rp;
  assign full = wp[PW-1] != rp[PW-1] && wp[PW-2:0] == rp[PW-2:0];
  assign head = mem[rp[PW-2:0]];
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent[g] = mem[rp[PW-2:0] + (PW-1)'(g)];
    assign vld[g] = PW'(g) < cnt;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[PW-2:0]] <= din;
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: load/ALU writeback arbiter with skid FIFO and pending scoreboard; forwarding enabled by RF_WB_FWD_EN
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [AWIDTH-1:0] issue_reg,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AWIDTH-1:0] alu_reg,
  input  logic [DWIDTH-1:0] alu_data,
  input  logic              ld_valid,
  input  logic [AWIDTH-1:0] ld_reg,
  input  logic [DWIDTH-1:0] ld_data,
  input  logic [AWIDTH-1:0] busy_sel,
  output logic              busy,
  output logic              fwd_valid,
  output logic [DWIDTH-1:0] fwd_data,
  output logic              write,
  output logic [AWIDTH-1:0] writeregsel,
  output logic [DWIDTH-1:0] writedata,
  output logic              err
);
`ifdef RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int NREG = 2 ** AWIDTH;
  beat_t head, nb;
  beat_t ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic full, empty, alu_acc, push, pop, fv;
  logic [DWIDTH-1:0] fd;
  logic [NREG-1:0] pend, set_m, clr_m;
  src_t sel;
  assign alu_ready = !full;
  assign alu_acc = alu_valid && !full;
  assign sel = ld_valid ? SRC_LD : !empty ? SRC_FIFO : alu_acc ? SRC_ALU : SRC_NONE;
  assign push = alu_acc && (ld_valid || !empty);
  assign pop = sel == SRC_FIFO;
  assign nb = sel == SRC_LD ? beat_t'{ld_reg, ld_data} : sel == SRC_FIFO ? head : beat_t'{alu_reg, alu_data};
  assign set_m = {NREG{issue_valid}} & (NREG'(1) << issue_reg);
  assign clr_m = {NREG{write}} & (NREG'(1) << writeregsel);
  assign busy = pend[busy_sel];
  wb_skid_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(beat_t'{alu_reg, alu_data}),
    .head(head),
    .full(full),
    .empty(empty),
    .ent(ent),
    .vld(vld)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      write <= 1'b0;
      writeregsel <= '0;
      writedata <= '0;
      err <= 1'b0;
      pend <= '0;
    end else begin
      write <= sel != SRC_NONE;
      writeregsel <= nb.regsel;
      writedata <= nb.data;
      pend <= (pend & ~clr_m) | set_m;
      err <= (issue_valid && pend[issue_reg] && !clr_m[issue_reg]) || (write && !pend[writeregsel]) || (ld_valid && full && alu_valid);
    end
  always_comb begin
    fv = write && writeregsel == busy_sel;
    fd = writedata;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && ent[i].regsel == busy_sel) begin
        fv = 1'b1;
        fd = ent[i].data;
      end
    if (alu_valid && alu_reg == busy_sel) begin
      fv = 1'b1;
      fd = alu_data;
    end
    if (ld_valid && ld_reg == busy_sel) begin
      fv = 1'b1;
      fd = ld_data;
    end
  end
  assign fwd_valid = FWD && fv;
  assign fwd_data = FWD && fv ? fd : '0;
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed and randomized checks of rf_writeback against a queue-based reference model
module tb_rf_writeback;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic issue_valid = 1'b0, alu_valid = 1'b0, ld_valid = 1'b0;
  logic [2:0] issue_reg = '0, alu_reg = '0, ld_reg = '0, busy_sel = '0;
  logic [15:0] alu_data = '0, ld_data = '0;
  logic alu_ready, busy, fwd_valid, write, err;
  logic [15:0] fwd_data, writedata;
  logic [2:0] writeregsel;
  int errors = 0, checks = 0;
  logic [18:0] q[$];
  logic [7:0] m_pend;
  logic m_write, m_err;
  logic [2:0] m_sel;
  logic [15:0] m_data;
  always #20 clk = ~clk;
  rf_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_reg(issue_reg),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .busy_sel(busy_sel), .busy(busy),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .write(write), .writeregsel(writeregsel),
    .writedata(writedata), .err(err)
  );
  task automatic model_step();
    logic full, acc, ierr, werr, ovf, ow;
    logic [18:0] out;
    if (!rst) begin
      q.delete();
      m_pend = '0;
      m_write = 1'b0;
      m_sel = '0;
      m_data = '0;
      m_err = 1'b0;
      return;
    end
    full = q.size() == DEPTH;
    acc = alu_valid && !full;
    ierr = issue_valid && m_pend[issue_reg] && !(m_write && m_sel == issue_reg);
    werr = m_write && !m_pend[m_sel];
    ovf = ld_valid && full && alu_valid;
    if (m_write) m_pend[m_sel] = 1'b0;
    if (issue_valid) m_pend[issue_reg] = 1'b1;
    ow = 1'b1;
    out = '0;
    if (ld_valid) begin
      out = {ld_reg, ld_data};
      if (acc) q.push_back({alu_reg, alu_data});
    end else if (q.size() > 0) begin
      out = q.pop_front();
      if (acc) q.push_back({alu_reg, alu_data});
    end else if (acc) out = {alu_reg, alu_data};
    else ow = 1'b0;
    m_err = ierr || werr || ovf;
    m_write = ow;
    if (ow) {m_sel, m_data} = out;
  endtask
  task automatic model_fwd(output logic v, output logic [15:0] d);
    v = 1'b0;
    d = '0;
`ifdef RF_WB_FWD_EN
    if (ld_valid && ld_reg == busy_sel) begin
      v = 1'b1;
      d = ld_data;
    end else if (alu_valid && alu_reg == busy_sel) begin
      v = 1'b1;
      d = alu_data;
    end else begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (!v && q[i][18:16] == busy_sel) begin
          v = 1'b1;
          d = q[i][15:0];
        end
      if (!v && m_write && m_sel == busy_sel) begin
        v = 1'b1;
        d = m_data;
      end
    end
`endif
  endtask
  task automatic drive(input logic iv, input logic [2:0] ir, input logic av, input logic [2:0] ar,
                       input logic [15:0] ad, input logic lv, input logic [2:0] lr,
                       input logic [15:0] ldd, input logic [2:0] bs);
    @(negedge clk);
    issue_valid = iv;
    issue_reg = ir;
    alu_valid = av;
    alu_reg = ar;
    alu_data = ad;
    ld_valid = lv;
    ld_reg = lr;
    ld_data = ldd;
    busy_sel = bs;
    #1;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", write); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (writeregsel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", writeregsel); end
    checks++; if (writedata !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", writedata); end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", alu_ready); end
    for (int b = 0; b < 8; b++) begin
      busy_sel = 3'(b);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy r%0d: got %b want 0", b, busy); end
    end
    tick();
    checks++; if (write !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL idle_out: got write=%b err=%b want 0 0", write, err); end
  endtask
  task automatic test_single_alu();
    drive(1, 3, 0, 0, 0, 0, 0, 0, 3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_pre: got %b want 0", busy); end
    tick();
    drive(0, 0, 1, 3, 16'h1234, 0, 0, 0, 3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_set: got %b want 1", busy); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", alu_ready); end
    tick();
    checks++; if (write !== 1'b1 || writeregsel !== 3'd3 || writedata !== 16'h1234) begin errors++; $display("FAIL single_write: got %b r%0d %h want 1 r3 1234", write, writeregsel, writedata); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_commit: got %b want 1", busy); end
    tick();
    checks++; if (write !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL single_after: got write=%b busy=%b err=%b want 0 0 0", write, busy, err); end
  endtask
  task automatic test_collision();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 2, 16'h5555, 1, 1, 16'hAAAA, 0);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL coll_ready0: got %b want 1", alu_ready); end
    tick();
    checks++; if (write !== 1'b1 || writeregsel !== 3'd1 || writedata !== 16'hAAAA) begin errors++; $display("FAIL coll_ld: got %b r%0d %h want 1 r1 aaaa", write, writeregsel, writedata); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL coll_ready1: got %b want 1", alu_ready); end
    tick();
    checks++; if (write !== 1'b1 || writeregsel !== 3'd2 || writedata !== 16'h5555) begin errors++; $display("FAIL coll_alu: got %b r%0d %h want 1 r2 5555", write, writeregsel, writedata); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (write !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL coll_idle: got write=%b err=%b want 0 0", write, err); end
  endtask
  task automatic test_fifo_full();
    for (int r = 1; r <= 6; r++) begin
      drive(1, 3'(r), 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 4, 16'h4444, 1, 1, 16'h0101, 0);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_a: got %b want 1", alu_ready); end
    tick();
    checks++; if (write !== 1'b1 || writeregsel !== 3'd1) begin errors++; $display("FAIL full_wr_a: got %b r%0d want 1 r1", write, writeregsel); end
    drive(0, 0, 1, 5, 16'h5555, 1, 2, 16'h0202, 0);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_b: got %b want 1", alu_ready); end
    tick();
    checks++; if (write !== 1'b1 || writeregsel !== 3'd2) begin errors++; $display("FAIL full_wr_b: got %b r%0d want 1 r2", write, writeregsel); end
    drive(0, 0, 1, 6, 16'h6666, 1, 3, 16'h0303, 0);
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL full_ready_c: got %b want 0", alu_ready); end
    tick();
    checks++; if (writeregsel !== 3'd3 || writedata !== 16'h0303 || err !== 1'b1) begin errors++; $display("FAIL full_wr_c: got r%0d %h err=%b want r3 0303 err=1", writeregsel, writedata, err); end
    drive(0, 0, 1, 6, 16'h6666, 0, 0, 0, 0);
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL full_ready_d: got %b want 0", alu_ready); end
    tick();
    checks++; if (write !== 1'b1 || writeregsel !== 3'd4 || writedata !== 16'h4444 || err !== 1'b0) begin errors++; $display("FAIL full_wr_d: got %b r%0d %h err=%b want 1 r4 4444 0", write, writeregsel, writedata, err); end
    drive(0, 0, 1, 6, 16'h6666, 0, 0, 0, 0);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_e: got %b want 1", alu_ready); end
    tick();
    checks++; if (write !== 1'b1 || writeregsel !== 3'd5 || writedata !== 16'h5555) begin errors++; $display("FAIL full_wr_e: got %b r%0d %h want 1 r5 5555", write, writeregsel, writedata); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (write !== 1'b1 || writeregsel !== 3'd6 || writedata !== 16'h6666) begin errors++; $display("FAIL full_wr_f: got %b r%0d %h want 1 r6 6666", write, writeregsel, writedata); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (write !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL full_idle: got write=%b err=%b want 0 0", write, err); end
  endtask
  task automatic test_errors();
    drive(1, 7, 0, 0, 0, 0, 0, 0, 7);
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_first_issue: got %b want 0", err); end
    drive(1, 7, 0, 0, 0, 0, 0, 0, 7);
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_double_issue: got %b want 1", err); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7);
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", err); end
    drive(0, 0, 0, 0, 0, 1, 7, 16'h7777, 7);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7);
    tick();
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL err_r7_clear: got busy=%b err=%b want 0 0", busy, err); end
    drive(0, 0, 1, 0, 16'h0F0F, 0, 0, 0, 0);
    tick();
    checks++; if (write !== 1'b1 || writeregsel !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL err_r0_write: got %b r%0d err=%b want 1 r0 0", write, writeregsel, err); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_nonpending: got %b want 1", err); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_nonpending_end: got %b want 0", err); end
  endtask
  task automatic test_forward();
    drive(1, 5, 0, 0, 0, 0, 0, 0, 5);
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 5);
    tick();
    drive(0, 0, 1, 5, 16'hBEEF, 1, 1, 16'h1111, 5);
`ifdef RF_WB_FWD_EN
    checks++; if (fwd_valid !== 1'b1 || fwd_data !== 16'hBEEF) begin errors++; $display("FWD FAIL fwd_alu_in: got %b %h want 1 beef", fwd_valid, fwd_data); end
`else
    checks++; if (fwd_valid !== 1'b0 || fwd_data !== 16'h0) begin errors++; $display("FAIL fwd_off_alu: got %b %h want 0 0000", fwd_valid, fwd_data); end
`endif
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5);
`ifdef RF_WB_FWD_EN
    checks++; if (fwd_valid !== 1'b1 || fwd_data !== 16'hBEEF) begin errors++; $display("FAIL fwd_fifo: got %b %h want 1 beef", fwd_valid, fwd_data); end
`else
    checks++; if (fwd_valid !== 1'b0 || fwd_data !== 16'h0) begin errors++; $display("FAIL fwd_off_fifo: got %b %h want 0 0000", fwd_valid, fwd_data); end
`endif
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fwd_busy: got %b want 1", busy); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5);
    checks++; if (write !== 1'b1 || writeregsel !== 3'd5 || writedata !== 16'hBEEF) begin errors++; $display("FAIL fwd_write: got %b r%0d %h want 1 r5 beef", write, writeregsel, writedata); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5);
    checks++; if (fwd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fwd_done: got fwd=%b busy=%b want 0 0", fwd_valid, busy); end
    tick();
  endtask
  task automatic test_random();
    logic ev;
    logic [15:0] ed;
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 63) != 0;
      drive($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            16'($urandom), $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 16'($urandom), 3'($urandom_range(0, 7)));
      checks++; if (alu_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready n=%0d: got %b want %b", n, alu_ready, q.size() < DEPTH); end
      checks++; if (busy !== m_pend[busy_sel]) begin errors++; $display("FAIL rnd_busy n=%0d: got %b want %b", n, busy, m_pend[busy_sel]); end
      model_fwd(ev, ed);
      checks++; if (fwd_valid !== ev || (ev && fwd_data !== ed)) begin errors++; $display("FAIL rnd_fwd n=%0d: got %b %h want %b %h", n, fwd_valid, fwd_data, ev, ed); end
`ifndef RF_WB_FWD_EN
      checks++; if (fwd_data !== 16'h0) begin errors++; $display("FAIL rnd_fwd_zero n=%0d: got %h want 0000", n, fwd_data); end
`endif
      tick();
      checks++; if (write !== m_write || (m_write && (writeregsel !== m_sel || writedata !== m_data))) begin errors++; $display("FAIL rnd_write n=%0d: got %b r%0d %h want %b r%0d %h", n, write, writeregsel, writedata, m_write, m_sel, m_data); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err n=%0d: got %b want %b", n, err, m_err); end
    end
  endtask
  initial begin
    test_reset();
    test_single_alu();
    test_collision();
    test_fifo_full();
    test_errors();
    test_forward();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Writer side of the 8x16 register file write port. Drives write/writeregsel/writedata from two result sources: the ALU and the load unit.
- Arbitrates the sources, buffers ALU results in a 2-entry skid FIFO, and registers the winning beat onto the write port.
- Keeps a per-register pending scoreboard that decode queries for RAW hazards.
- Sits between execute/memory and the register file.

Parameters:
- DWIDTH, 16, data width.
- AWIDTH, 3, register select width (2**AWIDTH registers).
- DEPTH, 2, ALU skid FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- issue_valid  in  1  decode issues an instruction with a destination register
- issue_reg  in  AWIDTH  destination register of the issued instruction
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_reg  in  AWIDTH  ALU destination register
- alu_data  in  DWIDTH  ALU result
- ld_valid  in  1  load result offered (load unit never stalls)
- ld_reg  in  AWIDTH  load destination register
- ld_data  in  DWIDTH  load data
- busy_sel  in  AWIDTH  scoreboard query register
- busy  out  1  busy_sel has a pending write (combinational)
- fwd_valid  out  1  forwarded value available for busy_sel
- fwd_data  out  DWIDTH  forwarded value
- write  out  1  register file write enable (registered)
- writeregsel  out  AWIDTH  register file write select (registered)
- writedata  out  DWIDTH  register file write data (registered)
- err  out  1  protocol error (registered)

Behaviour:
- Reset (rst==0 at posedge): write=0, writeregsel=0, writedata=0, err=0, FIFO empty, all pending bits 0. Reset mid-operation drops FIFO contents and in-flight beats.
- Clock and reset: one clock, clk; reset is synchronous and active-low, on port rst.
- Output register: at most one write per cycle. A beat selected in cycle N appears on write/writeregsel/writedata in cycle N+1, for one cycle. write=0 when nothing is selected.
- Selection priority:
  - A valid load always wins.
  - Otherwise the FIFO head wins.
  - Otherwise the ALU input goes direct (bypasses the FIFO, same 1-cycle latency).
- alu_ready = FIFO not full.
- An accepted ALU beat is enqueued when:
  - ld_valid=1, or
  - the FIFO is non-empty (preserves ALU order).
- Full FIFO plus a simultaneous dequeue: alu_ready stays 0 that cycle (no same-cycle refill).
- Pending bits:
  - Set on issue_valid.
  - Cleared in the cycle write=1 for that writeregsel.
  - Set and clear on the same register in the same cycle: set wins.
- busy = pending[busy_sel].
- err is set for one cycle after any of:
  - issue_valid to an already-pending register that is not being cleared that cycle;
  - write commits to a non-pending register;
  - ld_valid while the FIFO is full and alu_valid (overflow impossible by protocol, flagged).
- DEPTH wrap: read and write pointers are AWIDTH-independent, log2(DEPTH)+1 bits. Full = MSBs differ and the remaining bits are equal.

Optional Feature:
- RF_WB_FWD_EN defined:
  - fwd_valid=1 when busy_sel matches the output register (write=1), any valid FIFO entry, or the current ld/alu input.
  - Priority, youngest first: ld input, alu input, FIFO tail..head, output register.
  - fwd_data is the matching value.
- RF_WB_FWD_EN undefined: fwd_valid=0, fwd_data=0; the ports remain present.

Decomposition:
- Shared package holds:
  - DWIDTH and AWIDTH constants;
  - the writeback beat typedef {reg, data};
  - the source-select enum {SRC_NONE, SRC_LD, SRC_FIFO, SRC_ALU}.
- One natural sub-module: wb_skid_fifo, the parameterised DEPTH FIFO of beats with full/empty and per-entry visibility for forwarding.

Test Plan:
- Reset then idle: rst=0 two cycles, then issue nothing -> write=0, err=0, busy=0 for all busy_sel.
- Single ALU write: issue r3, then alu r3=0x1234 -> next cycle write=1, writeregsel=3, writedata=0x1234. busy(r3) is 1 until that cycle, then 0.
- Load/ALU collision: issue r1 and r2, same-cycle ld r1=0xAAAA and alu r2=0x5555 -> cycle+1 write r1=0xAAAA, cycle+2 write r2=0x5555, alu_ready stays 1.
- FIFO full: ld_valid held 3 cycles while ALU offers r4,r5,r6 -> r4 and r5 accepted, alu_ready=0 on the third. After the loads stop, r4 then r5 are written in order, then r6 is accepted.
- Errors:
  - issue r7 twice with no write between -> err=1 for one cycle.
  - ALU write to a non-pending r0 -> err=1 the cycle after the write commits.
- With RF_WB_FWD_EN: r5 queued behind a load, busy_sel=5 -> fwd_valid=1, fwd_data equals the queued value. Without the macro -> fwd_valid=0.
